// File: rtl/circle_tracer.sv
// Runs a lit segment (plus optional tail) around the outer ring of a row of
// 7-segment digits, clockwise, counter-clockwise or ping-pong, with a prescaled step rate.
module circle_tracer #(
  parameter int NUM_DISPLAYS = 6,
  parameter int TRAIL_LEN    = 1,
  parameter int DIV_W        = 24,
  parameter int PATH_LEN     = 2 * NUM_DISPLAYS + 4,
  parameter int POS_W        = $clog2(PATH_LEN)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [1:0]                mode_i,
  input  logic [DIV_W-1:0]          step_div_i,
  output logic [7*NUM_DISPLAYS-1:0] seg_o,
  output logic [POS_W-1:0]          head_pos_o,
  output logic                      dir_o,
  output logic                      wrap_o
);

  localparam int SEG_W  = 7 * NUM_DISPLAYS;
  localparam int HIST_D = (TRAIL_LEN > 1) ? TRAIL_LEN - 1 : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(PATH_LEN - 1);
  localparam logic [POS_W-1:0] ZERO_POS = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] ONE_POS  = {{(POS_W-1){1'b0}}, 1'b1};

  // Ring position to one-hot segment vector: top row, right side, bottom row reversed, left side.
  function automatic logic [SEG_W-1:0] pos_mask(input logic [POS_W-1:0] pos);
    int p;
    int bit_idx;
    logic [SEG_W-1:0] one;
    p   = int'(pos);
    one = {{(SEG_W-1){1'b0}}, 1'b1};
    if (p < NUM_DISPLAYS) begin
      bit_idx = 7 * p;
    end else if (p == NUM_DISPLAYS) begin
      bit_idx = 7 * (NUM_DISPLAYS - 1) + 1;
    end else if (p == NUM_DISPLAYS + 1) begin
      bit_idx = 7 * (NUM_DISPLAYS - 1) + 2;
    end else if (p <= 2 * NUM_DISPLAYS + 1) begin
      bit_idx = 7 * (2 * NUM_DISPLAYS + 1 - p) + 3;
    end else if (p == 2 * NUM_DISPLAYS + 2) begin
      bit_idx = 4;
    end else if (p == 2 * NUM_DISPLAYS + 3) begin
      bit_idx = 5;
    end else begin
      bit_idx = -1;
    end
    if (bit_idx >= 0) begin
      pos_mask = one << bit_idx;
    end else begin
      pos_mask = {SEG_W{1'b0}};
    end
  endfunction

  logic [DIV_W-1:0]             cnt_r;
  logic [POS_W-1:0]             head_r;
  logic                         dir_r;
  logic                         wrap_r;
  logic [SEG_W-1:0]             seg_r;
  logic [HIST_D-1:0][POS_W-1:0] hist_r;

  logic                         active_s;
  logic                         tick_s;
  logic [POS_W-1:0]             head_nxt_s;
  logic                         dir_nxt_s;
  logic                         wrap_nxt_s;
  logic [HIST_D-1:0][POS_W-1:0] hist_nxt_s;
  logic [SEG_W-1:0]             acc_s [HIST_D+1];
  logic [SEG_W-1:0]             seg_nxt_s;

  // A lowered step_div_i below the running count must still fire, hence >=.
  assign active_s = en_i && (mode_i != 2'b11);
  assign tick_s   = active_s && (cnt_r >= step_div_i);

  // Next head position, direction and wrap flag for the current mode.
  always_comb begin
    head_nxt_s = head_r;
    dir_nxt_s  = dir_r;
    wrap_nxt_s = 1'b0;
    case (mode_i)
      2'b00: begin
        dir_nxt_s = 1'b0;
        if (head_r == LAST_POS) begin
          head_nxt_s = ZERO_POS;
          wrap_nxt_s = 1'b1;
        end else begin
          head_nxt_s = head_r + ONE_POS;
        end
      end
      2'b01: begin
        dir_nxt_s = 1'b1;
        if (head_r == ZERO_POS) begin
          head_nxt_s = LAST_POS;
          wrap_nxt_s = 1'b1;
        end else begin
          head_nxt_s = head_r - ONE_POS;
        end
      end
      2'b10: begin
        if (!dir_r && (head_r == LAST_POS)) begin
          dir_nxt_s  = 1'b1;
          head_nxt_s = LAST_POS - ONE_POS;
          wrap_nxt_s = 1'b1;
        end else if (dir_r && (head_r == ZERO_POS)) begin
          dir_nxt_s  = 1'b0;
          head_nxt_s = ONE_POS;
          wrap_nxt_s = 1'b1;
        end else if (dir_r) begin
          head_nxt_s = head_r - ONE_POS;
        end else begin
          head_nxt_s = head_r + ONE_POS;
        end
      end
      default: begin
        head_nxt_s = head_r;
        dir_nxt_s  = dir_r;
        wrap_nxt_s = 1'b0;
      end
    endcase
  end

  assign hist_nxt_s[0] = head_r;
  assign acc_s[0]      = pos_mask(head_nxt_s);
  for (genvar i = 1; i < HIST_D; i++) begin : g_hist
    assign hist_nxt_s[i] = hist_r[i-1];
  end
  // Entries beyond the trail length exist only to keep the array non-empty.
  for (genvar i = 0; i < HIST_D; i++) begin : g_trail
    assign acc_s[i+1] = acc_s[i] | ((i < TRAIL_LEN - 1) ? pos_mask(hist_nxt_s[i]) : {SEG_W{1'b0}});
  end
  assign seg_nxt_s = acc_s[HIST_D];

  // Prescaler, head state, trail history and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r  <= {DIV_W{1'b0}};
      head_r <= ZERO_POS;
      dir_r  <= 1'b0;
      wrap_r <= 1'b0;
      hist_r <= '0;
      seg_r  <= {{(SEG_W-1){1'b0}}, 1'b1};
    end else if (tick_s) begin
      cnt_r  <= {DIV_W{1'b0}};
      head_r <= head_nxt_s;
      dir_r  <= dir_nxt_s;
      wrap_r <= wrap_nxt_s;
      hist_r <= hist_nxt_s;
      seg_r  <= seg_nxt_s;
    end else if (active_s) begin
      cnt_r  <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign seg_o      = seg_r;
  assign head_pos_o = head_r;
  assign dir_o      = dir_r;
  assign wrap_o     = wrap_r;

endmodule

// File: tb/tb_circle_tracer.sv
// Directed bench for circle_tracer: a ring-position model checked every cycle
// against a TRAIL_LEN=1 and a TRAIL_LEN=3 instance, plus hand-computed pins.
module tb_circle_tracer;
  localparam int N  = 6;
  localparam int DW = 24;
  localparam int SW = 7 * N;
  localparam int PL = 2 * N + 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic [SW-1:0] seg1, seg3;
  logic [3:0]    head1, head3;
  logic          dir1, dir3, wrap1, wrap3;

  circle_tracer #(.NUM_DISPLAYS(N), .TRAIL_LEN(1), .DIV_W(DW)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .step_div_i(div),
    .seg_o(seg1), .head_pos_o(head1), .dir_o(dir1), .wrap_o(wrap1));

  circle_tracer #(.NUM_DISPLAYS(N), .TRAIL_LEN(3), .DIV_W(DW)) dut3 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .step_div_i(div),
    .seg_o(seg3), .head_pos_o(head3), .dir_o(dir3), .wrap_o(wrap3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Model state: ring position, direction, prescaler count, last two heads.
  int m_pos = 0;
  int m_dir = 0;
  int m_cnt = 0;
  int m_h0 = 0;
  int m_h1 = 0;
  bit m_wrap = 1'b0;
  int m_wraps = 0;

  function automatic int seg_bit(int p);
    int digit;
    int letter; // 0=a .. 5=f
    if (p < N) begin digit = p; letter = 0; end
    else if (p == N) begin digit = N - 1; letter = 1; end
    else if (p == N + 1) begin digit = N - 1; letter = 2; end
    else if (p <= 2 * N + 1) begin digit = 2 * N + 1 - p; letter = 3; end
    else if (p == 2 * N + 2) begin digit = 0; letter = 4; end
    else begin digit = 0; letter = 5; end
    return 7 * digit + letter;
  endfunction

  function automatic logic [SW-1:0] mask(int p);
    logic [SW-1:0] m;
    m = '0;
    m[seg_bit(p)] = 1'b1;
    return m;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit tick;
    int prev;
    int np;
    @(posedge clk);
    m_wrap = 1'b0;
    if (rst) begin
      m_pos = 0; m_dir = 0; m_cnt = 0; m_h0 = 0; m_h1 = 0;
    end else if (en && mode != 2'b11) begin
      tick  = (m_cnt >= int'(div));
      m_cnt = tick ? 0 : m_cnt + 1;
      if (tick) begin
        prev = m_pos;
        if (mode == 2'b00) begin
          m_dir = 0;
          m_pos = (m_pos + 1) % PL;
          m_wrap = (prev == PL - 1);
        end else if (mode == 2'b01) begin
          m_dir = 1;
          m_pos = (m_pos + PL - 1) % PL;
          m_wrap = (prev == 0);
        end else begin
          np = (m_dir == 1) ? m_pos - 1 : m_pos + 1;
          if (np < 0 || np >= PL) begin
            m_dir = 1 - m_dir;
            np = (m_dir == 1) ? m_pos - 1 : m_pos + 1;
            m_wrap = 1'b1;
          end
          m_pos = np;
        end
        m_h1 = m_h0;
        m_h0 = prev;
        if (m_wrap) m_wraps++;
      end
    end
    #1;
    chk("head1", 64'(head1), 64'(m_pos));
    chk("head3", 64'(head3), 64'(m_pos));
    chk("dir1", 64'(dir1), 64'(m_dir));
    chk("dir3", 64'(dir3), 64'(m_dir));
    chk("wrap1", 64'(wrap1), 64'(m_wrap));
    chk("wrap3", 64'(wrap3), 64'(m_wrap));
    chk("seg1", 64'(seg1), 64'(mask(m_pos)));
    chk("seg3", 64'(seg3), 64'(mask(m_pos) | mask(m_h0) | mask(m_h1)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_wraps = 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; div = '0;
    #2;
    step();
    step();
    rst = 1'b0;
    chk("reset_seg", 64'(seg1), 64'h1);
    chk("reset_head", 64'(head1), 64'd0);

    // Clockwise full lap, one step per cycle.
    do_reset();
    en = 1'b1; mode = 2'b00; div = '0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) chk("cw_last_pos", 64'(head1), 64'd15);
    end
    chk("cw_lap_head", 64'(head1), 64'd0);
    chk("cw_wraps", 64'(m_wraps), 64'd1);

    // Counter-clockwise first step wraps to segment f of digit 0.
    do_reset();
    mode = 2'b01;
    step();
    chk("ccw_head", 64'(head1), 64'd15);
    chk("ccw_seg", 64'(seg1), 64'h20);
    chk("ccw_wrap", 64'(wrap1), 64'd1);
    chk("ccw_dir", 64'(dir1), 64'd1);

    // Ping-pong for 40 ticks.
    do_reset();
    mode = 2'b10;
    for (int i = 0; i < 40; i++) step();
    chk("pp_head", 64'(head1), 64'd10);
    chk("pp_wraps", 64'(m_wraps), 64'd2);

    // Reset mid-reversal traversal at head 7 going backward.
    do_reset();
    for (int i = 0; i < 23; i++) step();
    chk("pp_pre_head", 64'(head1), 64'd7);
    chk("pp_pre_dir", 64'(dir1), 64'd1);
    do_reset();
    chk("rst_mid_head", 64'(head1), 64'd0);
    chk("rst_mid_dir", 64'(dir1), 64'd0);
    chk("rst_mid_seg", 64'(seg1), 64'h1);

    // Prescaler divide-by-4 with an enable gap.
    mode = 2'b00; div = 24'd3;
    for (int i = 0; i < 4; i++) step();
    chk("div_first", 64'(head1), 64'd1);
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("div_frozen", 64'(head1), 64'd1);
    en = 1'b1;
    step();
    chk("div_not_yet", 64'(head1), 64'd1);
    step();
    chk("div_second", 64'(head1), 64'd2);

    // Lowering the divider below the count fires on the next enabled cycle.
    for (int i = 0; i < 3; i++) step();
    div = 24'd1;
    step();
    chk("div_lowered", 64'(head1), 64'd3);

    // Hold mode freezes everything, then a mode switch mid-flight.
    div = '0; mode = 2'b11;
    for (int i = 0; i < 3; i++) step();
    chk("hold_head", 64'(head1), 64'd3);
    mode = 2'b01;
    for (int i = 0; i < 5; i++) step();
    mode = 2'b10;
    for (int i = 0; i < 6; i++) step();

    // Three-segment trail after five clockwise ticks.
    do_reset();
    mode = 2'b00;
    for (int i = 0; i < 5; i++) step();
    chk("trail3_seg", 64'(seg3), (64'd1 << 35) | (64'd1 << 28) | (64'd1 << 21));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
